// File: rtl/acumulador_serial.sv
// Serial 4-bit accumulator: sums num_oper operands received over a valid/ready stream
// and presents the modulo-16 sum with a sticky carry flag on a valid/ready result port.

module Somador4Bits (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

module acumulador_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] num_oper,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_dado,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] soma,
    output logic       overflow,
    output logic       busy
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACUM   = 2'b01;
    localparam logic [1:0] RESULT = 2'b10;

    logic [1:0] state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;
    logic [3:0] sum;
    logic       carry;

    Somador4Bits u_somador (
        .A    (acc_q),
        .B    (in_dado),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (carry)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = 4'd0;
                    ovf_d   = 1'b0;
                    cnt_d   = num_oper;
                    state_d = (num_oper == 4'd0) ? RESULT : ACUM;
                end
            end
            ACUM: begin
                if (in_valid) begin
                    acc_d = sum;
                    ovf_d = ovf_q | carry;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            // The spare encoding recovers to IDLE on the next edge.
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 4'd0;
            cnt_q   <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACUM);
    assign out_valid = (state_q == RESULT);
    assign busy      = (state_q != IDLE);
    assign soma      = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/acumulador_serial.md
ACUMULADOR_SERIAL -- requirements
Module: acumulador_serial

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 4 bits, matching the downstream Somador4Bits adder stage.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin a new accumulation; sampled only in IDLE.
REQ-005 num_oper  input  4  operand count 0..15; sampled together with start.
REQ-006 in_valid  input  1  in_dado holds a valid operand.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 in_dado  input  4  unsigned operand.
REQ-009 out_valid  output  1  soma/overflow hold the final result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 soma  output  4  accumulated sum modulo 16.
REQ-012 overflow  output  1  sticky flag; set if any addition in the run produced a carry-out.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Addition SHALL use one instance of Somador4Bits: A=accumulator, B=in_dado, Cin=0; S feeds the accumulator, Cout feeds the overflow flag.
REQ-015 FSM states SHALL be IDLE, ACUM and RESULT, encoded as a 2-bit register; the unused code SHALL return to IDLE on the next edge.
REQ-016 IDLE with start=1 SHALL clear the accumulator and overflow, and load the remaining-operand counter with num_oper.
REQ-017 In that same IDLE cycle, the next state SHALL be RESULT if num_oper=0, otherwise ACUM.
REQ-018 IDLE with start=0 SHALL hold all state.
REQ-019 in_ready SHALL be 1 exactly when the state is ACUM; it is a combinational function of state only, not of in_valid.
REQ-020 A transfer occurs when in_valid=1 and in_ready=1 on a rising edge.
REQ-021 On each transfer: accumulator <= S; overflow <= overflow OR Cout; counter <= counter-1.
REQ-022 Cycles in ACUM with in_valid=0 SHALL change no state.
REQ-023 A transfer with counter=1 SHALL move the state to RESULT on the same edge.
REQ-024 The result SHALL therefore appear one cycle after the last transfer.
REQ-025 out_valid SHALL be 1 exactly in RESULT; soma and overflow SHALL be registered and stable throughout RESULT.
REQ-026 out_valid=1 and out_ready=1 SHALL return the state to IDLE; soma and overflow SHALL keep their values until the next accepted start.
REQ-027 While out_ready=0 the block SHALL stay in RESULT indefinitely, with in_ready=0.
REQ-028 start asserted outside IDLE SHALL be ignored, and num_oper SHALL not be re-sampled.
REQ-029 If start=1 in the IDLE cycle immediately after a handshake, the new run SHALL begin normally; there is no forced idle gap beyond that one IDLE cycle.
REQ-030 Accumulation SHALL wrap modulo 16; no saturation.

Reset
REQ-031 rst_n=0 SHALL asynchronously force: state=IDLE, accumulator=0, counter=0, overflow=0.
REQ-032 Consequently, during reset: soma=0, out_valid=0, in_ready=0, busy=0.
REQ-033 Reset asserted mid-run (ACUM or RESULT) SHALL abort the run; no partial result is reported.
REQ-034 After rst_n deasserts, the first edge SHALL behave as IDLE.

Verification
REQ-035 Nominal sum: num_oper=3; operands 3,4,5 with in_valid held high -> soma=12, overflow=0, out_valid rises 1 cycle after the 3rd transfer.
REQ-036 Wrap/carry: num_oper=2; operands 9,8 -> soma=1, overflow=1.
REQ-037 Sticky overflow: num_oper=3; operands 15,1,0 -> soma=0, overflow=1.
REQ-038 Flow control:
  - num_oper=2 with in_valid bubbles between operands 6,7 -> soma=13; bubble cycles do not decrement the counter.
  - Then out_ready=0 for 5 cycles -> out_valid, soma and overflow held, in_ready=0.
REQ-039 Zero operands: num_oper=0 with start -> next cycle out_valid=1, soma=0, overflow=0.
REQ-040 Ignored start and mid-run reset:
  - start pulses during ACUM and RESULT -> no effect.
  - rst_n=0 after the 1st of 3 operands -> soma=0, out_valid=0, busy=0 immediately, without waiting for a clock edge.
